// File: rtl/multdiv_ctrl_pkg.sv
// Shared encodings for the execute-stage mul/div sequencer. The exception codes
// are also used by the add/sub overflow path.
package multdiv_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } md_state_e;

  localparam logic [4:0] RSTATUS_REG_DEF = 5'd30;
  localparam int unsigned MUL_EXC_DEF    = 4;
  localparam int unsigned DIV_EXC_DEF    = 5;
  localparam int unsigned TO_EXC_DEF     = 6;

endpackage

// File: rtl/multdiv_ctrl_timeout_cnt.sv
// Saturating BUSY-cycle counter; hit flags the last permitted cycle (TIMEOUT-1).
module md_timeout_cnt #(
  parameter int CNT_W   = 6,
  parameter int TIMEOUT = 40
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic hit
);

  localparam logic [CNT_W-1:0] HIT_VAL = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] MAX_VAL = '1;

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != MAX_VAL)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign hit = (cnt == HIT_VAL);

endmodule

// File: rtl/multdiv_ctrl.sv
// Execute-stage sequencer for the shared iterative multiplier/divider: start pulse,
// pipeline stall while the unit works, one-cycle writeback of result or exception code.
module multdiv_ctrl
  import multdiv_ctrl_pkg::*;
#(
  parameter int          DATA_W      = 32,
  parameter int          TIMEOUT     = 40,
  parameter int          CNT_W       = 6,
  parameter logic [4:0]  RSTATUS_REG = RSTATUS_REG_DEF,
  parameter int unsigned MUL_EXC     = MUL_EXC_DEF,
  parameter int unsigned DIV_EXC     = DIV_EXC_DEF,
  parameter int unsigned TO_EXC      = TO_EXC_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              isMul_x,
  input  logic              isDiv_x,
  input  logic [4:0]        rd_x,
  input  logic [DATA_W-1:0] opA_x,
  input  logic [DATA_W-1:0] opB_x,
  input  logic              flush,
  input  logic              md_resultRDY,
  input  logic [DATA_W-1:0] md_result,
  input  logic              md_exception,
  output logic              ctrl_MULT,
  output logic              ctrl_DIV,
  output logic [DATA_W-1:0] md_opA,
  output logic [DATA_W-1:0] md_opB,
  output logic              stall,
  output logic              wb_valid,
  output logic [4:0]        wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              busy
);

  md_state_e  state_q, state_d;
  logic       start;
  logic       hit;
  logic [4:0] rd_q;
  logic       op_mul_q;

  assign start = (isMul_x | isDiv_x) & ~flush;

  // Counter is held at zero outside BUSY, so each operation starts counting from 0.
  md_timeout_cnt #(
    .CNT_W   (CNT_W),
    .TIMEOUT (TIMEOUT)
  ) u_timeout_cnt (
    .clock (clock),
    .reset (reset),
    .clr   (state_q != BUSY),
    .en    (state_q == BUSY),
    .hit   (hit)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = BUSY;
      BUSY: begin
        if (flush) begin
          state_d = IDLE;
        end else if (md_resultRDY || hit) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy  = (state_q != IDLE);
  // Gated by reset so stall is low while reset is asserted even if X holds a mul/div.
  assign stall = reset & (((state_q == IDLE) & start) | (state_q == BUSY));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ctrl_MULT <= 1'b0;
      ctrl_DIV  <= 1'b0;
      md_opA    <= '0;
      md_opB    <= '0;
      rd_q      <= '0;
      op_mul_q  <= 1'b0;
      wb_valid  <= 1'b0;
      wb_rd     <= '0;
      wb_data   <= '0;
    end else begin
      ctrl_MULT <= 1'b0;
      ctrl_DIV  <= 1'b0;
      wb_valid  <= 1'b0;
      if ((state_q == IDLE) && start) begin
        ctrl_MULT <= isMul_x;
        ctrl_DIV  <= ~isMul_x & isDiv_x;
        md_opA    <= opA_x;
        md_opB    <= opB_x;
        rd_q      <= rd_x;
        op_mul_q  <= isMul_x;
      end
      // Writeback fields are loaded on the BUSY->DONE edge so they are valid during DONE.
      if ((state_q == BUSY) && !flush) begin
        if (md_resultRDY) begin
          if (md_exception) begin
            wb_valid <= 1'b1;
            wb_rd    <= RSTATUS_REG;
            wb_data  <= op_mul_q ? DATA_W'(MUL_EXC) : DATA_W'(DIV_EXC);
          end else if (rd_q != 5'd0) begin
            wb_valid <= 1'b1;
            wb_rd    <= rd_q;
            wb_data  <= md_result;
          end
        end else if (hit) begin
          wb_valid <= 1'b1;
          wb_rd    <= RSTATUS_REG;
          wb_data  <= DATA_W'(TO_EXC);
        end
      end
    end
  end

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Bench for multdiv_ctrl: vector table of operations plus hand-written flush/reset sequences;
// writebacks are checked against a queue of expected {rd, data} records.
module tb_multdiv_ctrl;

  localparam int DATA_W = 32;

  logic              clock = 1'b0;
  logic              reset;
  logic              isMul_x, isDiv_x, flush, md_resultRDY, md_exception;
  logic [4:0]        rd_x;
  logic [DATA_W-1:0] opA_x, opB_x, md_result;
  logic              ctrl_MULT, ctrl_DIV, stall, wb_valid, busy;
  logic [DATA_W-1:0] md_opA, md_opB, wb_data;
  logic [4:0]        wb_rd;

  multdiv_ctrl #(.DATA_W(DATA_W)) dut (
    .clock        (clock),
    .reset        (reset),
    .isMul_x      (isMul_x),
    .isDiv_x      (isDiv_x),
    .rd_x         (rd_x),
    .opA_x        (opA_x),
    .opB_x        (opB_x),
    .flush        (flush),
    .md_resultRDY (md_resultRDY),
    .md_result    (md_result),
    .md_exception (md_exception),
    .ctrl_MULT    (ctrl_MULT),
    .ctrl_DIV     (ctrl_DIV),
    .md_opA       (md_opA),
    .md_opB       (md_opB),
    .stall        (stall),
    .wb_valid     (wb_valid),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .busy         (busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        is_mul;
    logic        is_div;
    logic [4:0]  rd;
    logic [31:0] a;
    logic [31:0] b;
    int          rdy_at;     // BUSY cycle (1-based) in which the unit answers; 0 = never
    logic [31:0] res;
    logic        exc;
    logic        exp_valid;
    logic [4:0]  exp_rd;
    logic [31:0] exp_data;
    int          exp_busy;   // BUSY cycles before DONE
    int          exp_mul;    // ctrl_MULT pulses
    int          exp_div;    // ctrl_DIV pulses
  } vec_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_t;

  wb_t  exp_q[$];
  vec_t vecs[9];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every writeback must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (reset === 1'b1 && wb_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_wb: got wb_rd=%0d wb_data=%0h, expected no writeback", wb_rd, wb_data);
      end else begin
        wb_t e;
        e = exp_q.pop_front();
        check("wb_rd", 32'(wb_rd), 32'(e.rd));
        check("wb_data", wb_data, e.data);
      end
    end
  end

  task automatic clear_inputs();
    isMul_x = 0; isDiv_x = 0; rd_x = 0; opA_x = 0; opB_x = 0;
    flush = 0; md_resultRDY = 0; md_exception = 0; md_result = 0;
  endtask

  // Issues one op in the next IDLE cycle and runs until DONE; returns at DONE's mid-cycle.
  // The X-stage inputs stay asserted through DONE, as a stalled pipeline would hold them.
  task automatic run_op(input vec_t v, input int idx);
    int  k, mp, dp;
    wb_t e;
    @(negedge clock);
    check($sformatf("v%0d_idle_before", idx), 32'(busy), 0);
    isMul_x = v.is_mul; isDiv_x = v.is_div; rd_x = v.rd; opA_x = v.a; opB_x = v.b;
    if (v.exp_valid) begin
      e.rd = v.exp_rd;
      e.data = v.exp_data;
      exp_q.push_back(e);
    end
    #1 check($sformatf("v%0d_stall_start", idx), 32'(stall), 1);
    k = 0; mp = 0; dp = 0;
    for (int guard = 0; guard < 100; guard++) begin
      @(negedge clock);
      md_resultRDY = 0; md_exception = 1; md_result = 32'hDEAD_BEEF;
      if (!(busy && stall)) break;
      k++;
      mp += int'(ctrl_MULT);
      dp += int'(ctrl_DIV);
      if (k == 1) begin
        check($sformatf("v%0d_md_opA", idx), md_opA, v.a);
        check($sformatf("v%0d_md_opB", idx), md_opB, v.b);
        check($sformatf("v%0d_first_pulse", idx), 32'({ctrl_MULT, ctrl_DIV}),
              32'({v.exp_mul == 1, v.exp_div == 1}));
      end
      if (k == v.rdy_at) begin
        md_resultRDY = 1; md_exception = v.exc; md_result = v.res;
      end
    end
    check($sformatf("v%0d_busy_cycles", idx), k, v.exp_busy);
    check($sformatf("v%0d_done_state", idx), 32'({busy, stall}), 32'b10);
    check($sformatf("v%0d_wb_valid", idx), 32'(wb_valid), 32'(v.exp_valid));
    check($sformatf("v%0d_mul_pulses", idx), mp, v.exp_mul);
    check($sformatf("v%0d_div_pulses", idx), dp, v.exp_div);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_stall"}, 32'(stall), 0);
    check({tag, "_ctrl"}, 32'({ctrl_MULT, ctrl_DIV}), 0);
    check({tag, "_md_opA"}, md_opA, 0);
    check({tag, "_md_opB"}, md_opB, 0);
    check({tag, "_wb_valid"}, 32'(wb_valid), 0);
    check({tag, "_wb_rd"}, 32'(wb_rd), 0);
    check({tag, "_wb_data"}, wb_data, 0);
  endtask

  initial begin
    //            mul div rd  a             b  rdy res           exc  v  rd  data          busy m d
    vecs[0] = '{1'b1, 1'b0, 5'd5,  32'd7,        32'd6, 3, 32'd42,        1'b0, 1'b1, 5'd5,  32'd42,        3,  1, 0};
    vecs[1] = '{1'b0, 1'b1, 5'd9,  32'd100,      32'd0, 2, 32'd0,         1'b1, 1'b1, 5'd30, 32'd5,         2,  0, 1};
    vecs[2] = '{1'b1, 1'b0, 5'd0,  32'd1,        32'd3, 1, 32'd3,         1'b0, 1'b0, 5'd0,  32'd0,         1,  1, 0};
    vecs[3] = '{1'b0, 1'b1, 5'd4,  32'd8,        32'd4, 2, 32'd2,         1'b0, 1'b1, 5'd4,  32'd2,         2,  0, 1};
    vecs[4] = '{1'b1, 1'b1, 5'd7,  32'd9,        32'd11,1, 32'd99,        1'b0, 1'b1, 5'd7,  32'd99,        1,  1, 0};
    vecs[5] = '{1'b1, 1'b0, 5'd3,  32'h8000_0000,32'd2, 2, 32'd0,         1'b1, 1'b1, 5'd30, 32'd4,         2,  1, 0};
    vecs[6] = '{1'b1, 1'b0, 5'd0,  32'd5,        32'd5, 4, 32'd0,         1'b1, 1'b1, 5'd30, 32'd4,         4,  1, 0};
    vecs[7] = '{1'b0, 1'b1, 5'd31, 32'hFFFF_FFFF,32'd1, 5, 32'hFFFF_FFFF, 1'b0, 1'b1, 5'd31, 32'hFFFF_FFFF, 5,  0, 1};
    vecs[8] = '{1'b1, 1'b0, 5'd12, 32'd1,        32'd2, 0, 32'd0,         1'b0, 1'b1, 5'd30, 32'd6,         40, 1, 0};

    reset = 0;
    clear_inputs();
    @(negedge clock);
    check_all_zero("por");
    @(negedge clock);
    reset = 1;

    // Back-to-back table: each op starts in the IDLE cycle right after the previous DONE.
    for (int i = 0; i < 9; i++) run_op(vecs[i], i);
    @(negedge clock);
    clear_inputs();
    check("after_timeout_idle", 32'(busy), 0);

    // mul/div in X while flush is high in IDLE must not start.
    @(negedge clock);
    isMul_x = 1; rd_x = 2; flush = 1;
    #1 check("idle_flush_stall", 32'(stall), 0);
    @(negedge clock);
    check("idle_flush_nostart", 32'(busy), 0);
    clear_inputs();

    // Flush in BUSY cycle 2, late ready in cycle 4 must be dropped.
    @(negedge clock);
    isDiv_x = 1; rd_x = 8; opA_x = 100; opB_x = 7;
    @(negedge clock);
    check("flush_b1_div", 32'(ctrl_DIV), 1);
    @(negedge clock);
    flush = 1; isDiv_x = 0;
    #1 check("flush_b2_stall", 32'(stall), 1);
    @(negedge clock);
    flush = 0;
    check("flush_idle_busy", 32'(busy), 0);
    check("flush_idle_stall", 32'(stall), 0);
    @(negedge clock);
    md_resultRDY = 1; md_result = 77;
    @(negedge clock);
    md_resultRDY = 0;
    repeat (2) begin
      @(negedge clock);
      check("flush_no_restart", 32'({busy, wb_valid}), 0);
    end

    // Asynchronous reset in the middle of BUSY.
    @(negedge clock);
    isMul_x = 1; rd_x = 6; opA_x = 3; opB_x = 4;
    repeat (2) @(negedge clock);
    check("rst_pre_busy", 32'(busy), 1);
    reset = 0;
    #1 check_all_zero("rst_mid");
    @(negedge clock);
    check_all_zero("rst_hold");
    clear_inputs();
    @(negedge clock);
    reset = 1;
    repeat (3) begin
      @(negedge clock);
      check("rst_after_quiet", 32'({busy, wb_valid}), 0);
    end
    run_op(vecs[0], 100);
    @(negedge clock);
    clear_inputs();
    repeat (3) @(negedge clock);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/multdiv_ctrl.md
Name: multdiv_ctrl

Overview:
- Sequences the shared iterative multiplier/divider for the execute stage of the 5-stage pipeline.
- Detects a mul/div instruction in X, then latches its operands and destination, and pulses the unit's start line.
- Holds the pipeline stalled until the unit reports ready, then issues a one-cycle writeback.
- Routes exceptions to $rstatus with fixed codes, and supports abort on pipeline flush plus a hard timeout.

Parameters:
- DATA_W, 32, operand/result width
- TIMEOUT, 40, max BUSY cycles before forced timeout exception
- CNT_W, 6, cycle-counter width; must satisfy 2^CNT_W > TIMEOUT
- RSTATUS_REG, 30, destination register for exception codes
- MUL_EXC, 4, rstatus code for mul overflow
- DIV_EXC, 5, rstatus code for divide by zero
- TO_EXC, 6, rstatus code for timeout

Ports:
- clock  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- isMul_x  in  1  mul instruction in X stage
- isDiv_x  in  1  div instruction in X stage
- rd_x  in  5  destination register of X instruction
- opA_x  in  DATA_W  operand A (rs value, bypassed)
- opB_x  in  DATA_W  operand B (rt value, bypassed)
- flush  in  1  pipeline flush (taken branch/jump behind X); aborts operation
- md_resultRDY  in  1  unit result valid (single-cycle pulse)
- md_result  in  DATA_W  unit result
- md_exception  in  1  unit exception, valid with md_resultRDY
- ctrl_MULT  out  1  one-cycle start pulse, multiply
- ctrl_DIV  out  1  one-cycle start pulse, divide
- md_opA  out  DATA_W  registered operand A to unit
- md_opB  out  DATA_W  registered operand B to unit
- stall  out  1  freeze F/D/X, insert bubble into M
- wb_valid  out  1  writeback request, one cycle
- wb_rd  out  5  writeback register
- wb_data  out  DATA_W  writeback value
- busy  out  1  state != IDLE

Behaviour:
- Reset (reset==0, async): state=IDLE, cnt=0. All outputs 0, including md_opA/md_opB/wb_rd/wb_data and latched rd/op.
- States: IDLE, BUSY, DONE.
- Start detect: start = (isMul_x | isDiv_x) & ~flush, evaluated only in IDLE.
- IDLE -> BUSY on start:
  - Register ctrl_MULT = isMul_x, ctrl_DIV = ~isMul_x & isDiv_x; mul has priority if both are set.
  - Latch md_opA/md_opB, rd, op type; cnt <= 0.
- Pulse timing: ctrl_MULT/ctrl_DIV are high exactly the first BUSY cycle, and only then.
- stall is combinational: high in IDLE when start=1, and high throughout BUSY. Low in DONE, which lets the mul/div instruction leave X.
- BUSY, in priority order:
  - flush=1 -> IDLE, no writeback, any later ready is dropped.
  - md_resultRDY=1 -> DONE; latch result and exception.
  - cnt == TIMEOUT-1 -> DONE with timeout exception.
  - Otherwise cnt <= cnt+1.
- DONE: one cycle, then IDLE. Registered outputs are valid during DONE:
  - wb_valid = 1.
  - If exception: wb_rd = RSTATUS_REG; wb_data = TO_EXC for timeout, else MUL_EXC or DIV_EXC per op.
  - Otherwise wb_rd = latched rd, wb_data = latched result.
  - Normal result with rd==0: wb_valid=0.
- DONE ignores isMul_x/isDiv_x, so the same instruction is not re-triggered.
- A new start is accepted in the IDLE cycle immediately following DONE, giving back-to-back ops one idle gap.
- Minimum latency: start cycle to wb_valid = 2 + N, where N = BUSY cycles until ready (ready in the first BUSY cycle gives N=1 → 3 cycles).
- md_resultRDY, md_exception or flush outside BUSY: ignored.
- md_exception is sampled only with md_resultRDY.
- Reset mid-operation: immediate IDLE, no writeback, no pulse.
- wb_data/wb_rd hold their last value when wb_valid=0. The bench checks them only when wb_valid=1.

Decomposition:
- Shared package: state encoding (IDLE=2'b00, BUSY=2'b01, DONE=2'b10), RSTATUS_REG, and exception codes MUL_EXC/DIV_EXC/TO_EXC. The same codes are used by the add/sub overflow path.
- Sub-module: md_timeout_cnt, the saturating cycle counter with clear/enable and a `hit` output at TIMEOUT-1.
- FSM and datapath registers live in the top-level module.

Test Plan:
- Mul normal: isMul_x=1, rd_x=5, opA=7, opB=6; ready after 3 BUSY cycles with result 42 -> ctrl_MULT pulses once, stall high 4 cycles, then wb_valid=1, wb_rd=5, wb_data=42.
- Div by zero: isDiv_x=1, rd_x=9, opB=0; ready with exception=1 -> wb_rd=30, wb_data=5; ctrl_DIV pulses once, ctrl_MULT stays 0.
- Timeout: isMul_x=1, md_resultRDY held 0 -> exactly TIMEOUT=40 BUSY cycles, then wb_rd=30, wb_data=6; returns to IDLE.
- Flush abort: start div, assert flush in BUSY cycle 2, then ready in cycle 4 -> no wb_valid, state IDLE, stall drops the cycle after flush.
- Back-to-back plus rd=0: mul rd=0 (result 3) then div rd=4 (result 2) -> first op gives no wb_valid, second gives wb_rd=4, wb_data=2; one IDLE cycle between ops.
- Async reset in BUSY: drive reset=0 mid-cycle -> all outputs 0 immediately, no writeback after release, next start behaves normally.
